// File: rtl/reorder_buffer_if.sv
// Issue / write-back / retire bus of the reorder buffer.
// master: issue stage + reservation station side; slave: the reorder buffer.
interface reorder_buffer_if #(
  parameter int unsigned TAG_W = 4,
  parameter int unsigned XLEN  = 32
);
  // allocation from issue
  logic             alloc_valid;
  logic [1:0]       alloc_type;
  logic [4:0]       alloc_rd;
  logic [XLEN-1:0]  alloc_pc;
  logic             alloc_pred;
  logic             alloc_ready;
  logic [TAG_W-1:0] alloc_tag;
  // write-back from the reservation station
  logic             wb_valid;
  logic [TAG_W-1:0] wb_tag;
  logic [XLEN-1:0]  wb_value;
  logic             wb_taken;
  logic [XLEN-1:0]  wb_target;
  // operand lookup
  logic [TAG_W-1:0] query_tag;
  logic             query_ready;
  logic [XLEN-1:0]  query_value;
  // retire
  logic             commit_valid;
  logic             commit_store;
  logic [4:0]       commit_rd;
  logic [XLEN-1:0]  commit_value;
  logic [TAG_W-1:0] commit_tag;
  logic             flush;
  logic [XLEN-1:0]  flush_pc;
  logic [TAG_W:0]   count;

  modport master (
    output alloc_valid, alloc_type, alloc_rd, alloc_pc, alloc_pred,
    output wb_valid, wb_tag, wb_value, wb_taken, wb_target, query_tag,
    input  alloc_ready, alloc_tag, query_ready, query_value,
    input  commit_valid, commit_store, commit_rd, commit_value, commit_tag,
    input  flush, flush_pc, count
  );

  modport slave (
    input  alloc_valid, alloc_type, alloc_rd, alloc_pc, alloc_pred,
    input  wb_valid, wb_tag, wb_value, wb_taken, wb_target, query_tag,
    output alloc_ready, alloc_tag, query_ready, query_value,
    output commit_valid, commit_store, commit_rd, commit_value, commit_tag,
    output flush, flush_pc, count
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates tags at issue, absorbs write-back,
// retires strictly in order and flushes on a branch mispredict found at retire.
// Optional macro ROB_BYPASS_EN: forwards a same-cycle write-back to the query port.
module reorder_buffer #(
  parameter int unsigned ROB_SIZE = 16,
  parameter int unsigned TAG_W    = 4,
  parameter int unsigned XLEN     = 32
) (
  input logic             clk,
  input logic             rst,
  input logic             rdy,
  reorder_buffer_if.slave rob
);
  localparam int unsigned CNT_W     = TAG_W + 1;
  localparam logic [1:0]  TY_REG    = 2'd0;
  localparam logic [1:0]  TY_STORE  = 2'd1;
  localparam logic [1:0]  TY_BRANCH = 2'd2;
  localparam logic [1:0]  TY_JUMP   = 2'd3;

  logic [ROB_SIZE-1:0] busy_q;
  logic [ROB_SIZE-1:0] done_q;
  logic [ROB_SIZE-1:0] pred_q;
  logic [ROB_SIZE-1:0] taken_q;
  logic [1:0]          type_q   [ROB_SIZE];
  logic [4:0]          rd_q     [ROB_SIZE];
  logic [XLEN-1:0]     pc_q     [ROB_SIZE];
  logic [XLEN-1:0]     value_q  [ROB_SIZE];
  logic [XLEN-1:0]     target_q [ROB_SIZE];
  logic [TAG_W-1:0]    head_q;
  logic [TAG_W-1:0]    tail_q;
  logic [CNT_W-1:0]    count_q;

  logic retire_c;
  logic mispredict_c;
  logic alloc_c;
  logic wb_c;

  // occupancy-derived handshake outputs
  assign rob.alloc_ready = (count_q < CNT_W'(ROB_SIZE));
  assign rob.alloc_tag   = tail_q;
  assign rob.count       = count_q;

  // retire / allocate / write-back qualifiers; a mispredict drops the allocate
  always_comb begin
    retire_c     = rdy & busy_q[head_q] & done_q[head_q];
    mispredict_c = retire_c && (type_q[head_q] == TY_BRANCH) &&
                   (taken_q[head_q] != pred_q[head_q]);
    alloc_c      = rdy & rob.alloc_valid & rob.alloc_ready & ~mispredict_c;
    wb_c         = rdy & rob.wb_valid & busy_q[rob.wb_tag];
  end

  // operand lookup, optionally forwarding the in-flight write-back
  always_comb begin
    rob.query_ready = busy_q[rob.query_tag] & done_q[rob.query_tag];
    rob.query_value = value_q[rob.query_tag];
`ifdef ROB_BYPASS_EN
    if (rob.wb_valid && (rob.wb_tag == rob.query_tag)) begin
      rob.query_ready = 1'b1;
      rob.query_value = rob.wb_value;
    end
`endif
  end

  // entry payload storage; validity is tracked by busy/done only
  always_ff @(posedge clk) begin
    if (alloc_c) begin
      type_q[tail_q] <= rob.alloc_type;
      rd_q[tail_q]   <= rob.alloc_rd;
      pc_q[tail_q]   <= rob.alloc_pc;
      pred_q[tail_q] <= rob.alloc_pred;
    end
    if (wb_c) begin
      value_q[rob.wb_tag]  <= rob.wb_value;
      taken_q[rob.wb_tag]  <= rob.wb_taken;
      target_q[rob.wb_tag] <= rob.wb_target;
    end
  end

  // pointers, status bits, occupancy and registered retire outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q           <= '0;
      done_q           <= '0;
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      rob.commit_valid <= 1'b0;
      rob.commit_store <= 1'b0;
      rob.commit_rd    <= '0;
      rob.commit_value <= '0;
      rob.commit_tag   <= '0;
      rob.flush        <= 1'b0;
      rob.flush_pc     <= '0;
    end else begin
      rob.commit_valid <= 1'b0;
      rob.commit_store <= 1'b0;
      rob.flush        <= 1'b0;
      if (mispredict_c) begin
        busy_q       <= '0;
        head_q       <= '0;
        tail_q       <= '0;
        count_q      <= '0;
        rob.flush    <= 1'b1;
        rob.flush_pc <= taken_q[head_q] ? target_q[head_q]
                                        : pc_q[head_q] + XLEN'(4);
      end else begin
        if (retire_c) begin
          busy_q[head_q] <= 1'b0;
          head_q         <= head_q + TAG_W'(1);
          unique case (type_q[head_q])
            TY_REG, TY_JUMP: begin
              if (rd_q[head_q] != 5'd0) begin
                rob.commit_valid <= 1'b1;
                rob.commit_rd    <= rd_q[head_q];
                rob.commit_value <= value_q[head_q];
                rob.commit_tag   <= head_q;
              end
            end
            TY_STORE: begin
              rob.commit_valid <= 1'b1;
              rob.commit_store <= 1'b1;
              rob.commit_rd    <= 5'd0;
              rob.commit_value <= value_q[head_q];
              rob.commit_tag   <= head_q;
            end
            default: ;
          endcase
        end
        if (wb_c) begin
          done_q[rob.wb_tag] <= 1'b1;
        end
        if (alloc_c) begin
          busy_q[tail_q] <= 1'b1;
          done_q[tail_q] <= 1'b0;
          tail_q         <= tail_q + TAG_W'(1);
        end
        unique case ({alloc_c, retire_c})
          2'b10:   count_q <= count_q + CNT_W'(1);
          2'b01:   count_q <= count_q - CNT_W'(1);
          default: ;
        endcase
      end
    end
  end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular reorder buffer directly downstream of the reservation station.
- Allocates a tag per issued instruction, absorbs RS write-back (tag, value, branch outcome), and retires entries strictly in order.
- Retired results go to the register file; retired stores go to the LSB.
- A mispredicted branch is detected at retire, which flushes all in-flight state and redirects fetch.

Parameters:
ROB_SIZE, 16, number of entries; power of two
TAG_W, 4, log2(ROB_SIZE); width of tags and pointers
XLEN, 32, data/address width

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-low (0 = reset)
rdy  in  1  global ready; when 0, no state changes
alloc_valid  in  1  issue stage requests an entry
alloc_type  in  2  0=reg-write, 1=store, 2=branch, 3=jump (writes link to rd)
alloc_rd  in  5  destination register
alloc_pc  in  XLEN  instruction PC
alloc_pred  in  1  predicted taken (branches)
alloc_ready  out  1  combinational; 1 when count < ROB_SIZE
alloc_tag  out  TAG_W  combinational; equals tail, the tag the next allocation receives
wb_valid  in  1  RS result valid
wb_tag  in  TAG_W  RS result tag
wb_value  in  XLEN  result (link value for jumps, address for stores)
wb_taken  in  1  actual branch outcome
wb_target  in  XLEN  branch target
query_tag  in  TAG_W  operand lookup tag
query_ready  out  1  combinational; entry busy and done
query_value  out  XLEN  combinational; stored value
commit_valid  out  1  registered one-cycle pulse; register write or store retire
commit_store  out  1  registered; retiring entry is a store
commit_rd  out  5  registered
commit_value  out  XLEN  registered
commit_tag  out  TAG_W  registered
flush  out  1  registered one-cycle pulse on mispredict
flush_pc  out  XLEN  registered redirect PC
count  out  TAG_W+1  occupancy, 0..ROB_SIZE

Behaviour:
- Reset (rst=0, async):
  - head=tail=count=0; all busy/done bits 0.
  - commit_valid, commit_store, commit_rd, commit_value, commit_tag, flush, flush_pc all 0.
  - Combinational outputs follow: alloc_ready=1, alloc_tag=0.
- Applies to every rule below: when rdy=0, pointers, entries and count hold, and commit_valid and flush are driven 0 at that edge.
- Allocate:
  - Fires when alloc_valid & alloc_ready & rdy.
  - Entry[tail] gets busy=1, done=0, plus type, rd, pc and pred.
  - tail <= tail+1, wrapping modulo ROB_SIZE.
- Write-back:
  - When wb_valid is set and entry[wb_tag] is busy: set done=1 and store value, taken and target.
  - Write-back to a non-busy entry is ignored.
- Retire:
  - At most one entry per cycle, when entry[head] is busy & done. Clear its busy bit; head <= head+1.
  - Reg-write or jump: commit_valid=1 and commit_rd/value/tag are loaded, only if rd != 0. If rd == 0, no pulse.
  - Store: commit_valid=1, commit_store=1, commit_value = stored value.
  - Branch with taken == pred: retired silently.
  - Branch with taken != pred: flush=1; flush_pc = taken ? target : pc+4.
  - Mispredict clears all busy bits; head=tail=count=0 next cycle.
- Retire latency: write-back at edge N makes the head eligible at edge N+1, so the commit pulse is visible after N+1.
- count: +1 on allocate, -1 on retire, unchanged when both happen.
- Full: when count=ROB_SIZE, alloc_ready=0, even if a retire happens the same cycle.
- Empty: no retire.
- Flush has priority over an allocate in the same cycle; the allocate is dropped and the requester must re-request.
- Write-back to the head in the same cycle it is checked: not retired until the next cycle.

Optional Feature:
- Macro: ROB_BYPASS_EN.
- Defined: when wb_valid and wb_tag == query_tag, query_ready=1 and query_value=wb_value in that same cycle, forwarding the write-back.
- Undefined: the query sees only stored state, so the result is visible one cycle after write-back.

Test Plan:
- Reset → alloc 3 reg-write (rd=5,6,7) → tags 0,1,2, count=3 → wb tag1=0x11, tag0=0x22 → commits rd5=0x22 then rd6=0x11 on consecutive cycles; rd7 is not committed.
- Fill 16 entries → alloc_ready=0, alloc_tag=0 (wrapped); retire one, alloc same cycle → alloc rejected; next cycle alloc_ready=1.
- Branch pc=0x100, pred=0, wb taken=1 target=0x200 → flush=1, flush_pc=0x200, count=0 next cycle; younger entries never commit.
- Branch pred=1 taken=0, pc=0x40 → flush_pc=0x44. Branch pred=taken → no flush, count decrements.
- Store alloc, wb value=0x8000 → commit_valid=1, commit_store=1, commit_value=0x8000. rd=0 reg-write retires with no pulse.
- rdy=0 for 3 cycles during a pending wb/alloc → no state change, no pulses; resume → identical sequence shifted 3 cycles. Assert rst mid-run → all outputs 0 immediately.
